// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with one-entry holding buffer, optional parity, 1/2 stop bits
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // Last data-bit count; for 8 data bits the 3-bit counter wraps to 0
    localparam logic [2:0] LP_LAST     = 3'(DATA_BITS);
    localparam logic       LP_HAS_PAR  = (PARITY != 0);
    localparam logic       LP_ODD      = (PARITY == 2);
    localparam logic       LP_TWO_STOP = (STOP_BITS == 2);

    logic                 r_baud_q;
    logic [DATA_BITS-1:0] r_buf;
    logic                 r_full;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [2:0]           r_cnt;
    logic                 r_stop_cnt;
    state_t               r_state;
    logic                 r_tx;
    logic                 r_tx_ready;
    logic                 r_busy;

    logic w_tick;
    logic w_accept;

    assign w_tick   = baud_clk & ~r_baud_q;
    assign w_accept = tx_valid & ~r_full;

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;
    assign busy     = r_busy;

    // Delay baud_clk by one clk so its rising edge becomes a one-cycle bit tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_q <= 1'b0;
        end else begin
            r_baud_q <= baud_clk;
        end
    end

    // Holding buffer handshake plus frame sequencer; every output is a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf      <= '0;
            r_full     <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_cnt      <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            // Accept only while empty; a load can only happen while full, so the two never collide
            if (w_accept) begin
                r_buf      <= tx_data;
                r_full     <= 1'b1;
                r_tx_ready <= 1'b0;
                r_busy     <= 1'b1;
            end

            if (w_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_full) begin
                            r_shift    <= r_buf;
                            r_par      <= (^r_buf) ^ LP_ODD;
                            r_full     <= 1'b0;
                            r_tx_ready <= 1'b1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end
                    end
                    S_START: begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_cnt   <= 3'd1;
                        r_state <= S_DATA;
                    end
                    S_DATA: begin
                        if (r_cnt != LP_LAST) begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_cnt   <= r_cnt + 3'd1;
                        end else if (LP_HAS_PAR) begin
                            r_tx    <= r_par;
                            r_state <= S_PAR;
                        end else begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= S_STOP;
                        end
                    end
                    S_PAR: begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= S_STOP;
                    end
                    S_STOP: begin
                        if (LP_TWO_STOP && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                        end else if (r_full) begin
                            // Next byte already waiting: start bit follows the stop bit directly
                            r_shift    <= r_buf;
                            r_par      <= (^r_buf) ^ LP_ODD;
                            r_full     <= 1'b0;
                            r_tx_ready <= 1'b1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= w_accept;
                        end
                    end
                    default: begin
                        r_tx    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx across three frame formats
module tb_uart_tx;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       run_baud = 1'b1;
    logic [2:0] bcnt     = 3'd0;
    logic       baud_clk;
    logic [2:0] valid    = 3'b000;
    logic [7:0] tdat [3];
    wire  [2:0] txw;
    wire  [2:0] rdyw;
    wire  [2:0] busyw;
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] rx_got[$];
    logic       rx_par_last;

    always #5 clk = ~clk;

    // Baud square wave with an 8-clk period; tick edge is the one where pre-edge bcnt == 4
    always @(posedge clk) begin
        if (run_baud) bcnt <= bcnt + 3'd1;
        cyc <= cyc + 1;
    end
    assign baud_clk = bcnt[2];

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_data(tdat[0]), .tx_valid(valid[0]),
        .tx_ready(rdyw[0]), .tx(txw[0]), .busy(busyw[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_data(tdat[1]), .tx_valid(valid[1]),
        .tx_ready(rdyw[1]), .tx(txw[1]), .busy(busyw[1]));
    uart_tx #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_data(tdat[2][6:0]), .tx_valid(valid[2]),
        .tx_ready(rdyw[2]), .tx(txw[2]), .busy(busyw[2]));

    function automatic int db(input int i);
        return (i == 2) ? 7 : 8;
    endfunction
    function automatic int par(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 2);
    endfunction
    function automatic int sb(input int i);
        return (i == 1) ? 2 : 1;
    endfunction
    function automatic logic [7:0] mask(input int i, input logic [7:0] b);
        return (i == 2) ? (b & 8'h7F) : b;
    endfunction

    task automatic send(input int idx, input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        while (rdyw[idx] !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (rdyw[idx] !== 1'b1) $display("FAIL send_ready[%0d]: tx_ready=%b, required 1", idx, rdyw[idx]);
        else n_pass++;
        tdat[idx]  = b;
        valid[idx] = 1'b1;
        @(posedge clk);
        #1;
        valid[idx] = 1'b0;
        tdat[idx]  = 8'($urandom);
    endtask

    // One bit period: 8 negedge samples, must be constant with busy high
    task automatic rx_bit(input int idx, output logic v, output logic ok);
        v  = txw[idx];
        ok = (busyw[idx] === 1'b1);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (txw[idx] !== v || busyw[idx] !== 1'b1) ok = 1'b0;
        end
        @(negedge clk);
    endtask

    // Decodes contiguous frames until the line goes idle
    task automatic rx_frames(input int idx, input int budget);
        int         waited = 0;
        int         ones;
        logic       v, ok, shape_ok, stop_ok, more, pexp;
        logic [7:0] d;
        rx_got.delete();
        @(negedge clk);
        while (txw[idx] !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (txw[idx] !== 1'b0) begin
            $display("FAIL rx_start[%0d]: tx=%b, required 0 within %0d cycles", idx, txw[idx], budget);
            return;
        end
        n_pass++;
        do begin
            rx_bit(idx, v, shape_ok);
            d       = 8'h00;
            ones    = 0;
            stop_ok = 1'b1;
            for (int i = 0; i < db(idx); i++) begin
                rx_bit(idx, v, ok);
                shape_ok &= ok;
                d[i] = v;
                ones += int'(v);
            end
            if (par(idx) != 0) begin
                rx_bit(idx, v, ok);
                shape_ok &= ok;
                rx_par_last = v;
                pexp = ((ones % 2) == 1) ^ (par(idx) == 2);
                n_checks++;
                if (v !== pexp) $display("FAIL rx_parity[%0d]: bit=%b, required %b (data %h)", idx, v, pexp, d);
                else n_pass++;
            end
            for (int s = 0; s < sb(idx); s++) begin
                rx_bit(idx, v, ok);
                shape_ok &= ok;
                stop_ok &= (v === 1'b1);
            end
            rx_got.push_back(d);
            n_checks++;
            if (!shape_ok) $display("FAIL rx_bit_shape[%0d]: a bit was not 8 steady cycles with busy=1, required steady", idx);
            else n_pass++;
            n_checks++;
            if (!stop_ok) $display("FAIL rx_stop[%0d]: stop bit low, required 1", idx);
            else n_pass++;
            more = (txw[idx] === 1'b0);
        end while (more && rx_got.size() < 8);
        n_checks++;
        if (txw[idx] !== 1'b1 || busyw[idx] !== 1'b0)
            $display("FAIL rx_idle[%0d]: tx=%b busy=%b, required 1/0", idx, txw[idx], busyw[idx]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (txw[i] !== 1'b1 || rdyw[i] !== 1'b1 || busyw[i] !== 1'b0)
                $display("FAIL reset_values[%0d]: tx/ready/busy=%b%b%b, required 110", i, txw[i], rdyw[i], busyw[i]);
            else n_pass++;
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (txw[i] !== 1'b1 || rdyw[i] !== 1'b1 || busyw[i] !== 1'b0)
                $display("FAIL idle_after_reset[%0d]: tx/ready/busy=%b%b%b, required 110", i, txw[i], rdyw[i], busyw[i]);
            else n_pass++;
        end
    endtask

    task automatic test_single_8n1();
        fork
            rx_frames(0, 100);
            send(0, 8'h55);
        join
        n_checks++;
        if (rx_got.size() != 1 || rx_got[0] !== 8'h55)
            $display("FAIL single_8n1: frames=%0d first=%h, required 1 frame of 55", rx_got.size(), rx_got[0]);
        else n_pass++;
    endtask

    task automatic test_parity();
        for (int t = 0; t < 3; t++) begin
            int         idx = (t == 1) ? 2 : 1;
            logic [7:0] b   = (t == 2) ? 8'h00 : 8'h07;
            logic       ep  = (t == 0);
            fork
                rx_frames(idx, 100);
                send(idx, b);
            join
            n_checks++;
            if (rx_got.size() != 1 || rx_got[0] !== b || rx_par_last !== ep)
                $display("FAIL parity_case%0d: data=%h par=%b, required %h/%b", t, rx_got[0], rx_par_last, b, ep);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int idx = 0; idx < 3; idx++) begin
            for (int r = 0; r < 4; r++) begin
                logic [7:0] b = 8'($urandom);
                fork
                    rx_frames(idx, 100);
                    send(idx, b);
                join
                n_checks++;
                if (rx_got.size() != 1 || rx_got[0] !== mask(idx, b))
                    $display("FAIL random[%0d]: got %h, required %h", idx, rx_got[0], mask(idx, b));
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int t1 = 0;
        int w  = 0;
        fork
            rx_frames(0, 100);
            begin
                send(0, 8'hA5);
                @(negedge clk);
                while (txw[0] !== 1'b0 && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                t1 = cyc;
                repeat (20) @(negedge clk);
                send(0, 8'h3C);
                w = 0;
                @(negedge clk);
                while (rdyw[0] !== 1'b1 && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                n_checks++;
                if ((cyc - t1) != 80 || txw[0] !== 1'b0)
                    $display("FAIL b2b_ready_rise: cycles=%0d tx=%b, required 80/0", cyc - t1, txw[0]);
                else n_pass++;
            end
        join
        n_checks++;
        if (rx_got.size() != 2 || rx_got[0] !== 8'hA5 || rx_got[1] !== 8'h3C)
            $display("FAIL b2b_frames: count=%0d, required 2 contiguous frames A5,3C", rx_got.size());
        else n_pass++;
    endtask

    task automatic test_held_valid();
        int acc = 0;
        fork
            rx_frames(0, 50);
            begin
                @(negedge clk);
                tdat[0]  = 8'hC3;
                valid[0] = 1'b1;
                for (int i = 0; i < 100; i++) begin
                    if (rdyw[0] === 1'b1) acc++;
                    @(negedge clk);
                end
                valid[0] = 1'b0;
            end
        join
        n_checks++;
        if (acc != 3) $display("FAIL held_accepts: accepts=%0d, required 3", acc);
        else n_pass++;
        n_checks++;
        if (rx_got.size() != acc || rx_got[0] !== 8'hC3 || rx_got[rx_got.size()-1] !== 8'hC3)
            $display("FAIL held_frames: frames=%0d, required %0d frames of C3", rx_got.size(), acc);
        else n_pass++;
    endtask

    task automatic test_tick_align();
        int phases[4] = '{4, 5, 3, 0};
        phases[3] = int'($urandom_range(0, 7));
        for (int t = 0; t < 4; t++) begin
            int         ph   = phases[t];
            int         expn = (((4 - ph) % 8) + 8) % 8;
            int         n    = 0;
            int         w    = 0;
            logic [7:0] b    = 8'($urandom);
            if (expn == 0) expn = 8;
            fork
                rx_frames(1, 100);
                begin
                    @(negedge clk);
                    while ((bcnt != 3'(ph) || rdyw[1] !== 1'b1) && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                    tdat[1]  = b;
                    valid[1] = 1'b1;
                    @(posedge clk);
                    #1;
                    valid[1] = 1'b0;
                    @(negedge clk);
                    while (txw[1] !== 1'b0 && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    n_checks++;
                    if (n != expn) $display("FAIL align_latency(phase %0d): %0d cycles, required %0d", ph, n, expn);
                    else n_pass++;
                end
            join
            n_checks++;
            if (rx_got.size() != 1 || rx_got[0] !== b)
                $display("FAIL align_data(phase %0d): got %h, required %h", ph, rx_got[0], b);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        int         w  = 0;
        logic       ok = 1'b1;
        logic [7:0] b2 = 8'($urandom);
        send(0, 8'($urandom) & 8'hF7);
        @(negedge clk);
        while (txw[0] !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (32) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (txw[0] !== 1'b1 || rdyw[0] !== 1'b1 || busyw[0] !== 1'b0)
            $display("FAIL reset_midframe: tx/ready/busy=%b%b%b, required 110", txw[0], rdyw[0], busyw[0]);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (txw[0] !== 1'b1 || busyw[0] !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) $display("FAIL no_resume: line left idle after reset release, required tx=1 busy=0");
        else n_pass++;
        fork
            rx_frames(0, 100);
            send(0, b2);
        join
        n_checks++;
        if (rx_got.size() != 1 || rx_got[0] !== b2)
            $display("FAIL after_reset_frame: got %h, required %h", rx_got[0], b2);
        else n_pass++;
    endtask

    task automatic test_baud_stop();
        int   w  = 0;
        logic ok = 1'b1;
        logic v;
        send(0, 8'h96);
        @(negedge clk);
        while (txw[0] !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (19) @(negedge clk);
        run_baud = 1'b0;
        @(negedge clk);
        v = txw[0];
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (txw[0] !== v || busyw[0] !== 1'b1) ok = 1'b0;
        end
        n_checks++;
        if (!ok) $display("FAIL baud_stop_hold: tx/busy changed while baud stopped, required tx=%b busy=1", v);
        else n_pass++;
        run_baud = 1'b1;
        w = 0;
        while (busyw[0] !== 1'b0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (busyw[0] !== 1'b0 || txw[0] !== 1'b1 || rdyw[0] !== 1'b1)
            $display("FAIL baud_resume: busy/tx/ready=%b%b%b, required 011", busyw[0], txw[0], rdyw[0]);
        else n_pass++;
    endtask

    initial begin
        tdat[0] = 8'h00;
        tdat[1] = 8'h00;
        tdat[2] = 8'h00;
        test_reset();
        test_single_8n1();
        test_parity();
        test_random();
        test_back_to_back();
        test_held_valid();
        test_tick_align();
        test_reset_midframe();
        test_baud_stop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
